wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, MDU write-queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset; one clock, no other clock domains.
REQ-004 SHALL have port w_valid  input  1  W-stage pipeline write request.
REQ-005 SHALL have ports w_pc/w_a3/w_wd  input  32/5/32  W-stage PC, destination, data.
REQ-006 SHALL have port m_valid  input  1  MDU late-result offer.
REQ-007 SHALL have port m_ready  output  1  queue can accept MDU result.
REQ-008 SHALL have ports m_pc/m_a3/m_wd  input  32/5/32  MDU PC, destination, data.
REQ-009 SHALL have ports grf_pc/grf_a3/grf_wd  output  32/5/32  registered write port driving GRF PC/A3/WD.
REQ-010 SHALL have port pend_mask  output  32  registers with queued, not-yet-issued MDU writes.

Function
REQ-011 MDU transfer SHALL occur on a cycle with m_valid && m_ready; m_ready SHALL equal (count < DEPTH), from registered count only.
REQ-012 W-stage request with w_a3==0 SHALL be treated as no request.
REQ-013 Each cycle the output register SHALL load, in priority: W-stage request; else FIFO head (popped); else bypass (REQ-024); else grf_a3=0, grf_wd=0, grf_pc=0.
REQ-014 Latency: W-stage request SHALL appear on grf_* exactly 1 cycle after the request edge.
REQ-015 MDU entries SHALL issue strictly in acceptance order; FIFO write/read pointers wrap modulo DEPTH.
REQ-016 Push and pop in the same cycle SHALL leave count unchanged, including at count==DEPTH-1 and count==1.
REQ-017 MDU transfer with m_a3==0 SHALL be acknowledged but not enqueued.
REQ-018 pend_mask bit r SHALL be 1 iff a valid FIFO entry targets r; bit 0 SHALL always be 0; computed combinationally from FIFO state.
REQ-019 W-stage write to r issued while FIFO holds entries targeting r SHALL invalidate those entries (WAW: newer pipeline write wins); invalidated entries pop without driving grf_a3 (output idles that slot).
REQ-020 W-stage traffic SHALL never be stalled; MDU starvation under continuous W traffic is permitted.

Reset
REQ-021 On reset: count=0, pointers=0, all entry valids=0, grf_pc=0, grf_a3=0, grf_wd=0, pend_mask=0, m_ready=1 in the following cycle.
REQ-022 Reset mid-operation SHALL discard all queued entries; an MDU handshake coincident with reset SHALL be dropped.

Configuration
REQ-023 Macro WB_ARBITER_BYPASS_EN SHALL select the bypass path.
REQ-024 Defined: with FIFO empty, no W request, and MDU transfer this cycle, the MDU result SHALL load the output register directly (1-cycle latency, not enqueued, no pend_mask bit). Undefined: every MDU result enqueues first (minimum 2-cycle latency).

Structure
REQ-025 Shared package/header (def.v) SHALL hold the GRF address width (5), data width (32), and zero-register constant.
REQ-026 The FIFO SHALL be a sub-module wb_fifo (entries {valid, pc, a3, wd}, push/pop/count, per-entry invalidate by address); arbitration and output register stay in wb_arbiter.

Verification
REQ-027 Reset then idle: grf_a3=0, pend_mask=0, m_ready=1 for 10 cycles.
REQ-028 w_valid, w_a3=8, w_wd=0x1234 with simultaneous MDU a3=9 wd=0xBEEF: next cycle grf_a3=8 wd=0x1234, pend_mask[9]=1; following cycle grf_a3=9 wd=0xBEEF, pend_mask=0.
REQ-029 Continuous w_valid (a3=1) while offering 3 MDU results: m_ready drops after 2 accepts (DEPTH=2); after w_valid deasserts, results issue in order on consecutive cycles.
REQ-030 MDU result a3=5 queued, then W write a3=5 wd=7: grf shows a3=5 wd=7, the queued entry never appears, pend_mask[5] clears.
REQ-031 Reset asserted with 2 queued entries: no queued write ever reaches grf_*; count=0.
REQ-032 Idle, MDU a3=3 wd=0x55: with WB_ARBITER_BYPASS_EN grf_a3=3 one cycle later; without, two cycles later.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared GRF write-back types: address/data widths, zero register and the
// queued MDU write entry layout.
package wb_arbiter_pkg;
    localparam int GRF_AW = 5;
    localparam int GRF_DW = 32;
    localparam int PC_W   = 32;
    localparam int NREGS  = 1 << GRF_AW;

    localparam logic [GRF_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [GRF_AW-1:0] a3;
        logic [GRF_DW-1:0] wd;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: W-stage request, MDU late-result handshake, GRF write port.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic              w_valid;
    logic [PC_W-1:0]   w_pc;
    logic [GRF_AW-1:0] w_a3;
    logic [GRF_DW-1:0] w_wd;

    logic              m_valid;
    logic              m_ready;
    logic [PC_W-1:0]   m_pc;
    logic [GRF_AW-1:0] m_a3;
    logic [GRF_DW-1:0] m_wd;

    logic [PC_W-1:0]   grf_pc;
    logic [GRF_AW-1:0] grf_a3;
    logic [GRF_DW-1:0] grf_wd;
    logic [NREGS-1:0]  pend_mask;

    modport slave (
        input  w_valid, w_pc, w_a3, w_wd,
        input  m_valid, m_pc, m_a3, m_wd,
        output m_ready, grf_pc, grf_a3, grf_wd, pend_mask
    );

    modport master (
        output w_valid, w_pc, w_a3, w_wd,
        output m_valid, m_pc, m_a3, m_wd,
        input  m_ready, grf_pc, grf_a3, grf_wd, pend_mask
    );
endinterface

// File: rtl/wb_fifo.sv
// MDU write queue: in-order FIFO whose entries can be invalidated by
// destination register; exports the mask of registers with pending writes.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  wb_entry_t                i_push_ent,
    input  logic                     i_pop,
    input  logic                     i_inv_en,
    input  logic [GRF_AW-1:0]        i_inv_a3,
    output wb_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [NREGS-1:0]         o_pend_mask
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t      r_ent [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic [NREGS-1:0] w_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (i_inv_en && r_ent[i].a3 == i_inv_a3) r_ent[i].valid <= 1'b0;
            // Popped slots are cleared so pend_mask only ever sees live entries
            if (i_pop) begin
                r_ent[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push) begin
                r_ent[r_wr_ptr] <= i_push_ent;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_ent[i].valid) w_pend[r_ent[i].a3] = 1'b1;
        w_pend[ZERO_REG] = 1'b0;
    end

    assign o_head      = r_ent[r_rd_ptr];
    assign o_count     = r_count;
    assign o_pend_mask = w_pend;
endmodule

// File: rtl/wb_arbiter.sv
// GRF write-port arbiter: W-stage writes win, queued MDU results fill idle
// slots. Define WB_ARBITER_BYPASS_EN to let an MDU result skip an empty queue.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    wb_arbiter_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic        w_wreq;
    logic        w_mxfer;
    logic        w_mkeep;
    logic        w_byp;
    logic        w_push;
    logic        w_pop;
    wb_entry_t   w_head;
    wb_entry_t   w_push_ent;
    logic [PW:0] w_count;

    logic [PC_W-1:0]   r_pc;
    logic [GRF_AW-1:0] r_a3;
    logic [GRF_DW-1:0] r_wd;

    assign w_wreq  = bus.w_valid && (bus.w_a3 != ZERO_REG);
    assign w_mxfer = bus.m_valid && bus.m_ready;
    assign w_mkeep = w_mxfer && (bus.m_a3 != ZERO_REG);

`ifdef WB_ARBITER_BYPASS_EN
    assign w_byp = w_mkeep && !w_wreq && (w_count == '0);
`else
    assign w_byp = 1'b0;
`endif

    assign w_push = w_mkeep && !w_byp;
    assign w_pop  = !w_wreq && (w_count != '0);

    // An MDU result arriving alongside a W write to the same register is
    // already stale: the pipeline write is the younger one.
    always_comb begin
        w_push_ent       = '0;
        w_push_ent.valid = !(w_wreq && bus.m_a3 == bus.w_a3);
        w_push_ent.pc    = bus.m_pc;
        w_push_ent.a3    = bus.m_a3;
        w_push_ent.wd    = bus.m_wd;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_ent  (w_push_ent),
        .i_pop       (w_pop),
        .i_inv_en    (w_wreq),
        .i_inv_a3    (bus.w_a3),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_pend_mask (bus.pend_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
            r_a3 <= '0;
            r_wd <= '0;
        end else if (w_wreq) begin
            r_pc <= bus.w_pc;
            r_a3 <= bus.w_a3;
            r_wd <= bus.w_wd;
        end else if (w_pop && w_head.valid) begin
            r_pc <= w_head.pc;
            r_a3 <= w_head.a3;
            r_wd <= w_head.wd;
        end else if (w_byp) begin
            r_pc <= bus.m_pc;
            r_a3 <= bus.m_a3;
            r_wd <= bus.m_wd;
        end else begin
            r_pc <= '0;
            r_a3 <= '0;
            r_wd <= '0;
        end
    end

    assign bus.m_ready = (w_count < FULL_CNT);
    assign bus.grf_pc  = r_pc;
    assign bus.grf_a3  = r_a3;
    assign bus.grf_wd  = r_wd;
endmodule
